// File: rtl/mux_pkg.sv
// Shared defaults and index-width helper for the round-robin N:1 mux.
// No ports; imported by rr_arbiter and mux_rr_nto1.
package mux_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NCH_DEF   = 4;

  // ceil(log2(n)), never below 1 so a 2-channel mux still has a bit
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: scans from (last+1) mod NCH upward with wrap.
// Ports: req[NCH] in, last in, grant[NCH] one-hot out, grant_idx out.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_idx
);

  int   j;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 1; k <= NCH; k++) begin
      j = int'(last) + k;
      if (j >= NCH) j = j - NCH;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N:1 registered mux with valid/ready on every channel and one output reg.
// Ports: clk, rst_n (async low), in_data/in_valid/in_ready per channel,
// out_data/out_valid/out_ready/out_src downstream.
// Build macro MUX_RR_ROUND_ROBIN_EN: rotating priority; otherwise fixed
// priority (lowest index wins) with no arbitration register.
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NCH   = NCH_DEF,
  localparam int IW    = idx_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_src
);

  logic             load;
  logic             xfer;
  logic [NCH-1:0]   grant;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    last;

  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    src_q, src_d;
  logic             valid_q, valid_d;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (in_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // output slot is free, or being drained this cycle
  assign load     = ~valid_q | out_ready;
  assign in_ready = (load & rst_n) ? grant : '0;
  assign xfer     = |in_ready;

`ifdef MUX_RR_ROUND_ROBIN_EN
  logic [IW-1:0] last_q, last_d;

  assign last_d = xfer ? grant_idx : last_q;
  assign last   = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IW'(NCH - 1);
    else        last_q <= last_d;
  end
`else
  // scanning from NCH-1 +1 wraps to 0: plain lowest-index priority
  assign last = IW'(NCH - 1);
`endif

  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q & ~out_ready;
    if (xfer) begin
      data_d  = in_data[grant_idx*WIDTH +: WIDTH];
      src_d   = grant_idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Bench for mux_rr_nto1: directed scenarios, then random traffic vs model.
// Model follows the MUX_RR_ROUND_ROBIN_EN setting of the build.
module tb_mux_rr_nto1;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_src;

  int tests = 0;
  int fails = 0;

  logic         m_ov;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_last;

  always #5 clk = ~clk;

  mux_rr_nto1 #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // winner by the arbitration rule; -1 when nobody requests
  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef MUX_RR_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic rstep();
    int           w;
    logic         ld;
    logic [N-1:0] er;
    @(negedge clk);
    in_valid  = N'($urandom);
    in_data   = (N*W)'($urandom);
    out_ready = ($urandom % 4) != 0;
    #1;
    ld = !m_ov || out_ready;
    w  = pick(in_valid, m_last);
    er = '0;
    if (ld && w >= 0) er[w] = 1'b1;
    chk("rnd_in_ready", 32'(in_ready), 32'(er));
    chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("rnd_out_data", 32'(out_data), 32'(m_data));
      chk("rnd_out_src", 32'(out_src), 32'(m_src));
    end
    @(posedge clk);
    if (ld && w >= 0) begin
      m_ov   = 1'b1;
      m_data = in_data[w*W +: W];
      m_src  = w;
      m_last = w;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    in_valid  = 4'b1111;
    in_data   = 16'hDCBA;
    out_ready = 1'b1;

    chk("pick_fixed_a", 32'(pick(4'b1010, 3)), 32'd1);
    chk("pick_none", 32'(pick(4'b0000, 1)), 32'hFFFF_FFFF);
`ifdef MUX_RR_ROUND_ROBIN_EN
    chk("pick_wrap", 32'(pick(4'b1001, 2)), 32'd3);
`else
    chk("pick_wrap", 32'(pick(4'b1001, 2)), 32'd0);
`endif

    // reset holds everything quiet even with all channels valid
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(in_ready), 32'b0001);

`ifdef MUX_RR_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) begin
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      @(posedge clk);
      #1;
      chk("rr_out_src", 32'(out_src), 32'(i % 4));
      chk("rr_out_data", 32'(out_data), 32'(4'hA + (i % 4)));
      @(negedge clk);
      #1;
    end
`else
    in_valid = 4'b1010;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("fp_in_ready", 32'(in_ready), 32'b0010);
      @(posedge clk);
      #1;
      chk("fp_out_src", 32'(out_src), 32'd1);
      chk("fp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      #1;
    end
`endif

    // backpressure: ch2 word held while ch0 waits
    @(negedge clk);
    in_valid  = 4'b0100;
    in_data   = {4'hD, 4'h5, 4'hB, 4'h7};
    out_ready = 1'b1;
    #1;
    chk("bp_load_ready", 32'(in_ready), 32'b0100);
    @(posedge clk);
    #1;
    chk("bp_load_data", 32'(out_data), 32'h5);
    @(negedge clk);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h5);
      chk("bp_hold_src", 32'(out_src), 32'd2);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("bp_rel_data", 32'(out_data), 32'h7);
    chk("bp_rel_src", 32'(out_src), 32'd0);

`ifdef MUX_RR_ROUND_ROBIN_EN
    @(negedge clk);
    in_valid = 4'b1000;
    @(negedge clk);
    in_valid = 4'b0100;
    #1;
    chk("wrap_ch2", 32'(in_ready), 32'b0100);
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    chk("skip_ch3", 32'(in_ready), 32'b1000);
    @(negedge clk);
    #1;
    chk("skip_ch0", 32'(in_ready), 32'b0001);
`endif

    // mid-run reset while a word is stalled
    @(negedge clk);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("mr_grant", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("mr_out_src", 32'(out_src), 32'd0);
    chk("mr_out_valid2", 32'(out_valid), 32'd1);

    // random traffic against the model from a clean reset
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_ov   = 1'b0;
    m_data = '0;
    m_src  = 0;
    m_last = N - 1;
    for (int i = 0; i < 2000; i++) rstep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
